// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset/power-up sequencer.
// State codes are exported on state_o, so their values are fixed.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == LOSS_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level input.
// Flops reset to 0 so a lock reads as lost until proven otherwise.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: syncs and debounces PLL locks, then releases
// N_STAGES active-low resets in order with programmable spacing.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_LOCKS       = 3,
  parameter int N_STAGES      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_DEBOUNCE = 1024,
  parameter int STAGE_DLY     = 256,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_LOCKS-1:0]  pll_lock_i,
  input  logic                sw_rst_req_i,
  output logic [N_STAGES-1:0] rst_n_o,
  output logic                all_ready_o,
  output logic [1:0]          state_o,
  output logic [7:0]          lock_loss_cnt_o
);

  localparam int STG_W =
    (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(LOCK_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DLY_LAST =
    CNT_W'(STAGE_DLY - 1);
  localparam logic [STG_W-1:0] STG_LAST =
    STG_W'(N_STAGES - 1);

  logic [N_LOCKS-1:0] lock_s;
  logic               lock_all_s;

  for (genvar i = 0; i < N_LOCKS; i++) begin : g_sync
    sync_bit #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (pll_lock_i[i]),
      .q_o   (lock_s[i])
    );
  end

  assign lock_all_s = &lock_s;

  seq_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STG_W-1:0]    stage_q;
  logic [N_STAGES-1:0] rst_n_q;
  logic                ready_q;
  logic [7:0]          loss_q;

  logic                loss_d;
  logic [N_STAGES-1:0] stage_mask_d;

  // A lock drop only counts once resets have started to release.
  assign loss_d = !lock_all_s &&
    (state_q == RELEASE || state_q == RUN);

  assign stage_mask_d = N_STAGES'(1) << stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else if (sw_rst_req_i || loss_d) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      if (loss_d) begin
        loss_q <= sat_inc8(loss_q);
      end
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (!lock_all_s) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            stage_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == DLY_LAST) begin
            cnt_q   <= '0;
            rst_n_q <= rst_n_q | stage_mask_d;
            if (stage_q == STG_LAST) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end else begin
              stage_q <= stage_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  assign rst_n_o         = rst_n_q;
  assign all_ready_o     = ready_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: vector table, corner sequences and a
// randomized run against an elapsed-cycle reference model.
module tb_rst_seq_ctrl;

  localparam int NL  = 2;
  localparam int NS  = 3;
  localparam int SS  = 2;
  localparam int HC  = 4;
  localparam int DEB = 8;
  localparam int DLY = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NL-1:0] pll_lock = '1;
  logic          sw = 1'b0;
  logic [NS-1:0] rst_n_o;
  logic          all_ready_o;
  logic [1:0]    state_o;
  logic [7:0]    loss_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int edge_n = 0;

  rst_seq_ctrl #(
    .N_LOCKS       (NL),
    .N_STAGES      (NS),
    .SYNC_STAGES   (SS),
    .HOLD_CYCLES   (HC),
    .LOCK_DEBOUNCE (DEB),
    .STAGE_DLY     (DLY),
    .CNT_W         (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pll_lock_i      (pll_lock),
    .sw_rst_req_i    (sw),
    .rst_n_o         (rst_n_o),
    .all_ready_o     (all_ready_o),
    .state_o         (state_o),
    .lock_loss_cnt_o (loss_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase + cycles spent in it; released stages
  // are derived by division rather than tracked one by one.
  int m_phase;
  int m_n;
  int m_rel;
  int m_loss;
  bit hist[$];

  function automatic void model_reset();
    m_phase = 0;
    m_n = 0;
    m_rel = 0;
    m_loss = 0;
    hist.delete();
  endfunction

  function automatic void model_edge(bit raw, bit req);
    bit seen;
    bit lost;
    seen = (hist.size() >= SS) ? hist[hist.size()-SS] : 1'b0;
    hist.push_back(raw);
    if (hist.size() > 8) void'(hist.pop_front());
    lost = !seen && (m_phase >= 2);
    if (req || lost) begin
      if (lost && m_loss < 255) m_loss++;
      m_phase = 0;
      m_n = 0;
      m_rel = 0;
    end else begin
      case (m_phase)
        0: begin
          m_n++;
          if (m_n == HC) begin m_phase = 1; m_n = 0; end
        end
        1: begin
          m_n = seen ? m_n + 1 : 0;
          if (m_n == DEB) begin m_phase = 2; m_n = 0; end
        end
        2: begin
          m_n++;
          m_rel = m_n / DLY;
          if (m_rel == NS) m_phase = 3;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [NS-1:0] model_rst();
    if (m_phase == 3) return '1;
    if (m_phase == 2) return NS'((1 << m_rel) - 1);
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @edge %0d: got %0h expected %0h",
                  nm, edge_n, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge(&pll_lock, sw);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) step();
  endtask

  // what: 0 waits on state_o, 1 waits on rst_n_o
  task automatic wait_for(input int what, input logic [2:0] val,
                          input int lim, input string nm,
                          output bit ok);
    int k;
    k = 0;
    ok = 1'b0;
    while (k < lim) begin
      if (what == 0 && state_o == val[1:0]) begin ok = 1'b1; break; end
      if (what == 1 && rst_n_o == val) begin ok = 1'b1; break; end
      step();
      k++;
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL %s timeout: got %0h expected %0h",
               nm, (what == 0) ? {1'b0, state_o} : rst_n_o, val);
    end
  endtask

  typedef struct {
    int         edge_no;
    logic [1:0] lock;
    logic       req;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit ok;
    int bad;
    logic [NL-1:0] mask;

    vecs.push_back('{1,  2'b11, 1'b0, 3'b000, 1'b0, 2'd0});
    vecs.push_back('{3,  2'b11, 1'b0, 3'b000, 1'b0, 2'd0});
    vecs.push_back('{4,  2'b11, 1'b0, 3'b000, 1'b0, 2'd1});
    vecs.push_back('{11, 2'b11, 1'b0, 3'b000, 1'b0, 2'd1});
    vecs.push_back('{12, 2'b11, 1'b0, 3'b000, 1'b0, 2'd2});
    vecs.push_back('{16, 2'b11, 1'b0, 3'b000, 1'b0, 2'd2});
    vecs.push_back('{17, 2'b11, 1'b0, 3'b001, 1'b0, 2'd2});
    vecs.push_back('{21, 2'b11, 1'b0, 3'b001, 1'b0, 2'd2});
    vecs.push_back('{22, 2'b11, 1'b0, 3'b011, 1'b0, 2'd2});
    vecs.push_back('{26, 2'b11, 1'b0, 3'b011, 1'b0, 2'd2});
    vecs.push_back('{27, 2'b11, 1'b0, 3'b111, 1'b1, 2'd3});
    vecs.push_back('{40, 2'b11, 1'b0, 3'b111, 1'b1, 2'd3});

    // Reset values while rst_n is held low
    #12;
    chk("reset_rst", rst_n_o, 3'b000);
    chk("reset_rdy", all_ready_o, 1'b0);
    chk("reset_state", state_o, 2'd0);
    chk("reset_loss", loss_o, 8'd0);

    // Power-up release timing
    pll_lock = 2'b11;
    do_reset();
    foreach (vecs[i]) begin
      pll_lock = vecs[i].lock;
      sw = vecs[i].req;
      run_to(vecs[i].edge_no);
      chk($sformatf("pwr_rst_e%0d", vecs[i].edge_no),
          rst_n_o, vecs[i].rst);
      chk($sformatf("pwr_rdy_e%0d", vecs[i].edge_no),
          all_ready_o, vecs[i].rdy);
      chk($sformatf("pwr_st_e%0d", vecs[i].edge_no),
          state_o, vecs[i].st);
    end

    // One-cycle lock glitch at debounce count 6
    do_reset();
    run_to(8);
    pll_lock = 2'b00;
    step();
    pll_lock = 2'b11;
    run_to(12);
    chk("glitch_state_e12", state_o, 2'd1);
    run_to(23);
    chk("glitch_rst_e23", rst_n_o, 3'b000);
    run_to(24);
    chk("glitch_rst_e24", rst_n_o, 3'b001);
    chk("glitch_loss", loss_o, 8'd0);

    // Lock loss in RUN
    run_to(60);
    chk("run_state", state_o, 2'd3);
    pll_lock = 2'b01;
    step();
    chk("loss_e1_rst", rst_n_o, 3'b111);
    step();
    chk("loss_e2_rst", rst_n_o, 3'b111);
    step();
    chk("loss_e3_rst", rst_n_o, 3'b000);
    chk("loss_e3_rdy", all_ready_o, 1'b0);
    chk("loss_e3_state", state_o, 2'd0);
    chk("loss_e3_cnt", loss_o, 8'd1);
    pll_lock = 2'b11;
    wait_for(0, 3'd3, 100, "relock_run", ok);
    if (ok) chk("relock_rst", rst_n_o, 3'b111);

    // Software request mid-RELEASE
    sw = 1'b1;
    step();
    sw = 1'b0;
    wait_for(1, 3'b001, 100, "sw_reach_001", ok);
    chk("sw_pre_state", state_o, 2'd2);
    sw = 1'b1;
    step();
    sw = 1'b0;
    chk("sw_rst", rst_n_o, 3'b000);
    chk("sw_state", state_o, 2'd0);
    chk("sw_loss", loss_o, 8'd1);

    // Saturating lock-loss counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      wait_for(0, 3'd2, 60, "sat_reach_rel", ok);
      if (!ok) break;
      pll_lock = 2'b00;
      step();
      pll_lock = 2'b11;
      step();
      step();
      if (i == 9) chk("sat_cnt10", loss_o, 8'd10);
      if (i == 254) chk("sat_cnt255", loss_o, 8'd255);
    end
    chk("sat_cnt300", loss_o, 8'd255);

    // Asynchronous reset mid-RELEASE
    wait_for(1, 3'b001, 100, "async_reach_001", ok);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", rst_n_o, 3'b000);
    chk("async_state", state_o, 2'd0);
    chk("async_loss", loss_o, 8'd0);
    chk("async_rdy", all_ready_o, 1'b0);

    // Randomized run against the model
    pll_lock = 2'b11;
    do_reset();
    bad = 0;
    mask = '1;
    for (int c = 0; c < 4000; c++) begin
      step();
      chk("rnd", {rst_n_o, all_ready_o, state_o, loss_o},
          {model_rst(), (m_phase == 3) ? 1'b1 : 1'b0,
           2'(m_phase), 8'(m_loss)});
      if (bad > 0) begin
        bad--;
        pll_lock = (bad > 0) ? mask : '1;
      end else if ($urandom_range(0, 99) == 0) begin
        bad = $urandom_range(1, 4);
        mask = NL'($urandom_range(0, 2));
        pll_lock = mask;
      end
      sw = ($urandom_range(0, 299) == 0);
    end
    sw = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
